// File: rtl/uart_pkg.sv
// uart_pkg: scheduler state encoding and line configuration shared by the UART blocks
package uart_pkg;
   typedef enum logic [1:0] {IDLE, ISSUE, WAIT_DONE, GAP} sched_state_t;
   typedef struct packed {
      logic parity_en;
      logic parity_type;
      logic stop_bits;
   } uart_cfg_t;
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick, searching upward from ptr_i+1 with wrap
module rr_arbiter #(
   parameter int NUM_REQ = 4,
   localparam int IW = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req_i,
   input  logic [IW-1:0]      ptr_i,
   output logic [NUM_REQ-1:0] gnt_o,
   output logic [IW-1:0]      idx_o
);
   // Walk from lowest to highest priority so the last hit is the winner.
   always_comb begin
      gnt_o = '0;
      idx_o = '0;
      for (int i = NUM_REQ; i >= 1; i--) begin
         if (req_i[(int'(ptr_i) + i) % NUM_REQ]) begin
            gnt_o = '0;
            gnt_o[(int'(ptr_i) + i) % NUM_REQ] = 1'b1;
            idx_o = IW'((int'(ptr_i) + i) % NUM_REQ);
         end
      end
   end
endmodule

// File: rtl/uart_tx_sched.sv
// uart_tx_sched: round-robin sharing of one UART transmitter between byte producers,
// with frame-completion watchdog, inter-frame gap and between-frame config updates
module uart_tx_sched
   import uart_pkg::*;
#(
   parameter int NUM_REQ        = 4,
   parameter int GAP_CYCLES     = 0,
   parameter int TIMEOUT_CYCLES = 4096
) (
   input  logic                       clk_i,
   input  logic                       arst_i,
   input  logic [NUM_REQ-1:0]         req_valid_i,
   input  logic [NUM_REQ*8-1:0]       req_data_i,
   output logic [NUM_REQ-1:0]         req_ready_o,
   input  logic                       cfg_parity_en_i,
   input  logic                       cfg_parity_type_i,
   input  logic                       cfg_stop_bits_i,
   output logic                       cfg_parity_en_o,
   output logic                       cfg_parity_type_o,
   output logic                       cfg_stop_bits_o,
   output logic [7:0]                 tx_data_o,
   output logic                       tx_data_valid_o,
   input  logic                       tx_data_ready_i,
   input  logic                       tx_done_i,
   output logic [$clog2(NUM_REQ)-1:0] gnt_id_o,
   output logic                       busy_o,
   output logic                       timeout_o
);
   localparam int IW      = $clog2(NUM_REQ);
   localparam int CNT_TOP = (TIMEOUT_CYCLES > GAP_CYCLES) ? TIMEOUT_CYCLES : GAP_CYCLES;
   localparam int CW      = (CNT_TOP < 1) ? 1 : $clog2(CNT_TOP + 1);

   sched_state_t       state_q, state_d;
   logic [IW-1:0]      ptr_q, ptr_d, gnt_q, gnt_d, win_idx;
   logic [NUM_REQ-1:0] win_gnt;
   logic [7:0]         data_q, data_d, win_data;
   logic               valid_q, valid_d;
   logic [CW-1:0]      cnt_q, cnt_d;
   uart_cfg_t          cfg_q, cfg_d, cfg_in;
   logic               expire, frame_end;

   rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
      .req_i (req_valid_i),
      .ptr_i (ptr_q),
      .gnt_o (win_gnt),
      .idx_o (win_idx)
   );

   assign cfg_in    = '{parity_en: cfg_parity_en_i, parity_type: cfg_parity_type_i, stop_bits: cfg_stop_bits_i};
   assign expire    = (TIMEOUT_CYCLES != 0) && (cnt_q == CW'(TIMEOUT_CYCLES));
   assign frame_end = tx_done_i || expire;

   always_comb begin
      win_data = '0;
      for (int k = 0; k < NUM_REQ; k++)
         if (win_gnt[k]) win_data = req_data_i[8*k +: 8];
   end

   always_ff @(posedge clk_i or posedge arst_i) begin
      if (arst_i) begin
         state_q <= IDLE;
         ptr_q   <= IW'(NUM_REQ - 1);
         gnt_q   <= '0;
         data_q  <= '0;
         valid_q <= 1'b0;
         cnt_q   <= '0;
         cfg_q   <= '0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         gnt_q   <= gnt_d;
         data_q  <= data_d;
         valid_q <= valid_d;
         cnt_q   <= cnt_d;
         cfg_q   <= cfg_d;
      end
   end

   // One counter serves both the done watchdog and the gap timer; it saturates rather than wraps.
   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      gnt_d   = gnt_q;
      data_d  = data_q;
      valid_d = valid_q;
      cnt_d   = cnt_q;
      cfg_d   = cfg_q;
      case (state_q)
         IDLE: begin
            cfg_d = cfg_in;
            if (|req_valid_i) begin
               state_d = ISSUE;
               ptr_d   = win_idx;
               gnt_d   = win_idx;
               data_d  = win_data;
               valid_d = 1'b1;
            end
         end
         ISSUE: if (tx_data_ready_i) begin
            state_d = WAIT_DONE;
            valid_d = 1'b0;
            cnt_d   = '0;
         end
         WAIT_DONE: if (frame_end) begin
            state_d = (GAP_CYCLES == 0) ? IDLE : GAP;
            cnt_d   = CW'(1);
         end else begin
            cnt_d = (&cnt_q) ? cnt_q : cnt_q + 1'b1;
         end
         GAP: if (cnt_q >= CW'(GAP_CYCLES)) state_d = IDLE;
              else cnt_d = cnt_q + 1'b1;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      req_ready_o       = (state_q == IDLE && !arst_i) ? win_gnt : '0;
      tx_data_o         = data_q;
      tx_data_valid_o   = valid_q;
      gnt_id_o          = gnt_q;
      busy_o            = state_q != IDLE;
      timeout_o         = state_q == WAIT_DONE && expire && !tx_done_i;
      cfg_parity_en_o   = cfg_q.parity_en;
      cfg_parity_type_o = cfg_q.parity_type;
      cfg_stop_bits_o   = cfg_q.stop_bits;
   end
endmodule

// File: tb/tb_uart_tx_sched.sv
// tb_uart_tx_sched: directed scenarios plus random traffic, checked every cycle
// against a timestamp-based behavioural model of the scheduler
module tb_uart_tx_sched;
   localparam int G = 4;
   localparam int T = 16;

   logic        clk, arst;
   logic [3:0]  req_valid, req_ready;
   logic [31:0] req_data;
   logic        pe, pt, sb, pe_o, pt_o, sb_o;
   logic [7:0]  tx_data;
   logic        tx_valid, tx_ready, tx_done;
   logic [1:0]  gnt_id;
   logic        busy, tmo;

   int tests = 0, fails = 0;

   uart_tx_sched #(.NUM_REQ(4), .GAP_CYCLES(G), .TIMEOUT_CYCLES(T)) dut (
      .clk_i(clk), .arst_i(arst),
      .req_valid_i(req_valid), .req_data_i(req_data), .req_ready_o(req_ready),
      .cfg_parity_en_i(pe), .cfg_parity_type_i(pt), .cfg_stop_bits_i(sb),
      .cfg_parity_en_o(pe_o), .cfg_parity_type_o(pt_o), .cfg_stop_bits_o(sb_o),
      .tx_data_o(tx_data), .tx_data_valid_o(tx_valid), .tx_data_ready_i(tx_ready),
      .tx_done_i(tx_done), .gnt_id_o(gnt_id), .busy_o(busy), .timeout_o(tmo)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
      tests++;
      if (act !== exp_v) begin
         fails++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp_v, $time);
      end
   endtask

   task automatic fail_now(input string nm);
      tests++;
      fails++;
      $display("FAIL %s: bounded wait expired at %0t", nm, $time);
   endtask

   function automatic int pick(input logic [3:0] v, input int p);
      for (int i = 1; i <= 4; i++)
         if (v[(p + i) % 4]) return (p + i) % 4;
      return -1;
   endfunction

   // Model: phase 0 idle, 1 byte offered, 2 frame in flight, 3 gap; timing kept as cycle stamps.
   int cyc = 0, ph = 0, mptr = 3, mgnt = 0, t_wait = 0, t_idle = 0;
   logic [7:0] mdata = '0;
   logic [2:0] mcfg = '0;

   always @(negedge clk) begin : cmp
      logic [3:0] er;
      int w;
      logic eto;
      #1;
      if (arst) begin
         ph = 0; mptr = 3; mgnt = 0; mdata = '0; mcfg = '0;
      end
      w = pick(req_valid, mptr);
      er = '0;
      if (!arst && ph == 0 && w >= 0) er[w] = 1'b1;
      eto = !arst && ph == 2 && (cyc - t_wait == T) && !tx_done;
      chk("req_ready", req_ready, er);
      chk("tx_valid", tx_valid, ph == 1);
      chk("tx_data", tx_data, mdata);
      chk("gnt_id", gnt_id, mgnt);
      chk("busy", busy, ph != 0);
      chk("timeout", tmo, eto);
      chk("cfg", {pe_o, pt_o, sb_o}, mcfg);
      if (!arst) begin
         case (ph)
            0: begin
               mcfg = {pe, pt, sb};
               if (w >= 0) begin
                  mdata = req_data[8*w +: 8];
                  mgnt = w; mptr = w; ph = 1;
               end
            end
            1: if (tx_ready) begin ph = 2; t_wait = cyc + 1; end
            2: if (tx_done || cyc - t_wait == T) begin
               t_idle = cyc + G + 1;
               ph = (G == 0) ? 0 : 3;
            end
            default: if (cyc + 1 == t_idle) ph = 0;
         endcase
      end
      cyc++;
   end

   task automatic nxt();
      @(negedge clk);
   endtask

   task automatic do_reset();
      nxt();
      arst = 1'b1; req_valid = '0; req_data = '0; tx_ready = 1'b0; tx_done = 1'b0;
      pe = 1'b0; pt = 1'b0; sb = 1'b0;
      nxt();
      nxt();
      arst = 1'b0;
   endtask

   task automatic wait_acc();
      for (int i = 0; i < 60; i++) begin
         if (i > 0) nxt();
         #2;
         if (req_ready != 0) return;
      end
      fail_now("accept_wait");
   endtask

   task automatic finish_frame(input int dly);
      repeat (dly + 1) nxt();
      tx_done = 1'b1;
      nxt();
      tx_done = 1'b0;
   endtask

   task automatic serve(input int dly);
      nxt();
      req_valid = '0;
      tx_ready = 1'b1;
      for (int i = 0; i < 40; i++) begin
         #2;
         if (tx_valid && tx_ready) begin
            finish_frame(dly);
            return;
         end
         nxt();
      end
      fail_now("handshake_wait");
   endtask

   initial begin
      #1000000;
      $display("FAIL global_timeout at %0t", $time);
      $fatal(1);
   end

   initial begin : stim
      logic [7:0] got_d [5];
      logic [1:0] got_g [5];
      logic [7:0] exp_d [5] = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h10};
      logic [1:0] exp_g [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
      int n, first, pulses;
      arst = 1'b1; req_valid = '0; req_data = '0; tx_ready = 1'b0; tx_done = 1'b0;
      pe = 1'b0; pt = 1'b0; sb = 1'b0;
      do_reset();
      #2;
      chk("reset_busy", busy, 0);
      chk("reset_gnt", gnt_id, 0);
      chk("reset_data", tx_data, 0);
      // single request, then gap spacing to the next accept
      nxt();
      req_valid = 4'b0001; req_data[7:0] = 8'hA5; tx_ready = 1'b1;
      #2;
      chk("single_ready", req_ready, 4'b0001);
      nxt();
      req_valid = '0;
      #2;
      chk("single_valid", tx_valid, 1);
      chk("single_data", tx_data, 8'hA5);
      chk("single_gnt", gnt_id, 0);
      nxt();
      #2;
      chk("single_valid_drop", tx_valid, 0);
      chk("single_busy", busy, 1);
      repeat (7) nxt();
      nxt();
      tx_done = 1'b1;
      for (n = 1; n <= 20; n++) begin
         nxt();
         if (n == 1) begin
            tx_done = 1'b0; req_valid = 4'b0100; req_data[23:16] = 8'h5A;
         end
         #2;
         if (req_ready != 0) break;
      end
      chk("gap_spacing", n, G + 1);
      serve(2);
      // fairness with every requester continuously valid
      do_reset();
      req_valid = 4'hF; req_data = 32'h13121110; tx_ready = 1'b1;
      for (int f = 0; f < 5; f++) begin
         wait_acc();
         nxt();
         #2;
         got_d[f] = tx_data;
         got_g[f] = gnt_id;
         finish_frame(0);
      end
      for (int f = 0; f < 5; f++) begin
         chk("fair_data", got_d[f], exp_d[f]);
         chk("fair_gnt", got_g[f], exp_g[f]);
      end
      // backpressure
      do_reset();
      req_valid = 4'b1000; req_data = 32'h3C000000; tx_ready = 1'b0;
      wait_acc();
      for (int i = 0; i < 5; i++) begin
         nxt();
         #2;
         chk("bp_valid", tx_valid, 1);
         chk("bp_data", tx_data, 8'h3C);
         chk("bp_no_second_ready", req_ready, 0);
      end
      nxt();
      req_valid = '0; tx_ready = 1'b1;
      #2;
      chk("bp_handshake", tx_valid, 1);
      finish_frame(1);
      // config frozen until idle
      do_reset();
      req_valid = 4'b0001; tx_ready = 1'b1;
      wait_acc();
      nxt();
      req_valid = '0;
      nxt();
      pe = 1'b1;
      #2;
      chk("cfg_freeze_wait", pe_o, 0);
      nxt();
      tx_done = 1'b1;
      #2;
      chk("cfg_freeze_done", pe_o, 0);
      nxt();
      tx_done = 1'b0;
      for (n = 0; n < 12; n++) begin
         #2;
         if (!busy) break;
         chk("cfg_freeze_gap", pe_o, 0);
         nxt();
      end
      if (n == 12) fail_now("cfg_idle_wait");
      chk("cfg_first_idle", pe_o, 0);
      nxt();
      #2;
      chk("cfg_applied", pe_o, 1);
      // watchdog
      do_reset();
      req_valid = 4'b0001; tx_ready = 1'b1;
      wait_acc();
      nxt();
      req_valid = '0;
      first = -1; pulses = 0;
      for (int k = 0; k < 40; k++) begin
         nxt();
         #2;
         if (tmo) begin
            pulses++;
            if (first < 0) first = k;
         end
      end
      chk("timeout_delay", first, T);
      chk("timeout_pulses", pulses, 1);
      nxt();
      req_valid = 4'b0010;
      wait_acc();
      chk("timeout_next_ready", req_ready, 4'b0010);
      serve(0);
      // reset in the middle of a frame
      do_reset();
      req_valid = 4'b0010; req_data[15:8] = 8'h77; tx_ready = 1'b1;
      wait_acc();
      nxt();
      req_valid = '0;
      #2;
      chk("rst_pre_gnt", gnt_id, 1);
      nxt();
      #2;
      chk("rst_pre_busy", busy, 1);
      nxt();
      arst = 1'b1;
      #2;
      chk("rst_busy", busy, 0);
      chk("rst_valid", tx_valid, 0);
      chk("rst_data", tx_data, 0);
      chk("rst_gnt", gnt_id, 0);
      nxt();
      arst = 1'b0; req_valid = 4'b0011;
      #2;
      chk("rst_rr_restart", req_ready, 4'b0001);
      serve(0);
      // random traffic, checked by the model every cycle
      for (int i = 0; i < 3000; i++) begin
         nxt();
         arst = $urandom_range(0, 299) == 0;
         req_valid = 4'($urandom) & 4'($urandom);
         req_data = $urandom;
         tx_ready = $urandom_range(0, 9) < 7;
         tx_done = $urandom_range(0, 9) == 0;
         if ($urandom_range(0, 19) == 0) {pe, pt, sb} = 3'($urandom);
      end
      nxt();
      arst = 1'b0; req_valid = '0; tx_done = 1'b0;
      nxt();
      #3;
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
